// File: rtl/aes_host_driver.sv
// aes_host_driver: runs one upstream job at a time through the AES core command port and returns the result
module aes_host_driver #(
    parameter logic [4:0] OPC_KEY = 5'd0,
    parameter logic [4:0] OPC_ENC = 5'd1,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] job_key,
    input  logic [127:0] job_block,
    input  logic         job_new_key,
    output logic         aes_input_valid,
    input  logic         aes_input_ready,
    output logic [4:0]   aes_opcode,
    output logic [255:0] aes_data_in,
    input  logic         aes_busy,
    input  logic         aes_output_valid,
    output logic         aes_output_ready,
    input  logic [127:0] aes_data_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_data,
    output logic         res_err,
    output logic         key_loaded
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, SEND_KEY, WAIT_KEY, SEND_BLK, WAIT_RES, ERR, DELIVER} state_t;
    state_t state, state_nx;
    logic [255:0] key_q, stored_key;
    logic [127:0] blk_q;
    logic [CW-1:0] cnt;
    logic out_of_reset;
    logic timed_out;
    assign timed_out = cnt == CW'(TIMEOUT - 1);
    // next state and command/handshake outputs decoded from the current state
    always_comb begin
        state_nx = state;
        job_ready = (state == IDLE) && out_of_reset;
        aes_input_valid = (state == SEND_KEY) || (state == SEND_BLK);
        aes_opcode = (state == SEND_KEY) ? OPC_KEY : (state == SEND_BLK) ? OPC_ENC : 5'd0;
        aes_data_in = (state == SEND_KEY) ? key_q : (state == SEND_BLK) ? {128'd0, blk_q} : 256'd0;
        aes_output_ready = state == WAIT_RES;
        res_valid = state == DELIVER;
        unique case (state)
            IDLE:     if (job_valid && out_of_reset)
                          state_nx = (job_new_key || !key_loaded || job_key != stored_key) ? SEND_KEY : SEND_BLK;
            SEND_KEY: if (aes_input_ready) state_nx = WAIT_KEY;
            WAIT_KEY: state_nx = !aes_busy ? SEND_BLK : timed_out ? ERR : WAIT_KEY;
            SEND_BLK: if (aes_input_ready) state_nx = WAIT_RES;
            WAIT_RES: state_nx = aes_output_valid ? DELIVER : timed_out ? ERR : WAIT_RES;
            ERR:      state_nx = DELIVER;
            DELIVER:  if (res_ready) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end
    // state register, job latch, wait counter, key tracking and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            out_of_reset <= 1'b0;
            key_q <= '0;
            blk_q <= '0;
            stored_key <= '0;
            key_loaded <= 1'b0;
            cnt <= '0;
            res_data <= '0;
            res_err <= 1'b0;
        end else begin
            state <= state_nx;
            out_of_reset <= 1'b1;
            if (job_valid && job_ready) begin
                key_q <= job_key;
                blk_q <= job_block;
            end
            if (aes_input_valid && aes_input_ready)
                cnt <= '0;
            else if ((state == WAIT_KEY || state == WAIT_RES) && cnt != '1)
                cnt <= cnt + CW'(1);
            if (state == WAIT_KEY && !aes_busy) begin
                key_loaded <= 1'b1;
                stored_key <= key_q;
            end
            if (state == WAIT_RES && aes_output_valid) begin
                res_data <= aes_data_out;
                res_err <= 1'b0;
            end
            if (state == ERR) begin
                res_data <= '0;
                res_err <= 1'b1;
                key_loaded <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_aes_host_driver.sv
// tb_aes_host_driver: randomized jobs against a transaction-level model of the driver and a behavioural AES core
module tb_aes_host_driver;
    localparam int T = 8;
    localparam logic [4:0] OPC_KEY = 5'd0;
    localparam logic [4:0] OPC_ENC = 5'd1;
    localparam logic [127:0] MIX = {16{8'hA5}};

    logic clk = 0;
    logic reset = 1;
    logic job_valid = 0, job_new_key = 0, job_ready;
    logic [255:0] job_key = '0;
    logic [127:0] job_block = '0;
    logic aes_input_valid, aes_input_ready = 0, aes_output_ready;
    logic [4:0] aes_opcode;
    logic [255:0] aes_data_in;
    logic aes_busy = 0, aes_output_valid = 0;
    logic [127:0] aes_data_out = '0;
    logic res_valid, res_ready = 0, res_err, key_loaded;
    logic [127:0] res_data;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    aes_host_driver #(.OPC_KEY(OPC_KEY), .OPC_ENC(OPC_ENC), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_key(job_key), .job_block(job_block), .job_new_key(job_new_key),
        .aes_input_valid(aes_input_valid), .aes_input_ready(aes_input_ready), .aes_opcode(aes_opcode), .aes_data_in(aes_data_in),
        .aes_busy(aes_busy), .aes_output_valid(aes_output_valid), .aes_output_ready(aes_output_ready), .aes_data_out(aes_data_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err), .key_loaded(key_loaded)
    );

    typedef struct { logic [4:0] op; logic [255:0] d; } cmd_t;
    typedef struct { logic [127:0] d; logic e; logic kl; int lat; } res_t;
    cmd_t cq[$];
    res_t rq[$];
    logic loaded_m = 0;
    logic [255:0] key_m = '0;
    logic [255:0] core_key = '0;
    logic [255:0] pool [3];

    // per-job core behaviour: p_* chosen by the source, c_* for the job in flight
    // rmode: 0 answer after rd cycles, 1 never answer, 2 answer on the timeout cycle, 3 answer one cycle too late
    int p_kb = 0, p_rd = 0, p_rmode = 0, c_kb = 0, c_rd = 0, c_rmode = 0;
    bit p_stuck = 0, c_stuck = 0;
    bit ir_always = 1, rr_always = 1;
    int ir_hold = 0, rr_hold = 0;
    int busy_left = 0, res_cnt = 0, late_hold = 0;
    bit busy_stuck = 0, armed = 0;
    int cyc = 0, t0 = 0, cmd_n = 0, res_n = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_job_ready"}, job_ready, 0);
        chk({tag, "_aes_input_valid"}, aes_input_valid, 0);
        chk({tag, "_aes_opcode"}, aes_opcode, 0);
        chk({tag, "_aes_data_in"}, aes_data_in, 0);
        chk({tag, "_aes_output_ready"}, aes_output_ready, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_err"}, res_err, 0);
        chk({tag, "_key_loaded"}, key_loaded, 0);
    endtask

    task automatic offer(input logic [255:0] k, input logic [127:0] b, input bit nk, input int kb, input bit st, input int rd, input int rm);
        int n;
        n = 0;
        p_kb = kb; p_stuck = st; p_rd = rd; p_rmode = rm;
        job_key = k; job_block = b; job_new_key = nk; job_valid = 1;
        do begin
            @(negedge clk);
            n++;
        end while (!job_ready && n < 300);
        chk("job_accepted", job_ready, 1);
        @(posedge clk);
        #2;
        job_valid = 0;
        job_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        job_block = {$urandom, $urandom, $urandom, $urandom};
        job_new_key = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (rq.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drained", rq.size(), 0);
        @(posedge clk);
        #2;
    endtask

    // model update and checks at negedge; core and consumer responses driven just after posedge
    initial begin : engine
        logic pv_iv, pv_ir, pv_rv, pv_rr, pv_re, rst_seen, need, kfail, err;
        logic [4:0] pv_op, h_op;
        logic [255:0] pv_d, h_d;
        logic [127:0] pv_rd, res_val;
        bit job_hs, cmd_hs, out_hs, res_hs;
        cmd_t c;
        res_t r;
        int kp;
        pv_iv = 0; pv_ir = 0; pv_rv = 0; pv_rr = 0; pv_re = 0; pv_op = '0; pv_d = '0; pv_rd = '0; res_val = '0;
        forever begin
            @(negedge clk);
            cyc++;
            rst_seen = reset;
            job_hs = job_valid && job_ready;
            cmd_hs = aes_input_valid && aes_input_ready;
            out_hs = aes_output_valid && aes_output_ready;
            res_hs = res_valid && res_ready;
            h_op = aes_opcode;
            h_d = aes_data_in;
            if (!reset) begin
                if (pv_iv && !pv_ir) begin
                    chk("cmd_hold_valid", aes_input_valid, 1);
                    chk("cmd_hold_opcode", aes_opcode, pv_op);
                    chk("cmd_hold_data", aes_data_in, pv_d);
                end
                if (pv_rv && !pv_rr) begin
                    chk("res_hold_valid", res_valid, 1);
                    chk("res_hold_data", res_data, pv_rd);
                    chk("res_hold_err", res_err, pv_re);
                end
                chk("cmd_and_ack_exclusive", aes_input_valid && aes_output_ready, 0);
                if (res_valid) begin
                    chk("deliver_job_ready_low", job_ready, 0);
                    chk("deliver_no_cmd", aes_input_valid, 0);
                    chk("deliver_no_ack", aes_output_ready, 0);
                end
                if (res_valid && !pv_rv) begin
                    chk("result_expected", rq.size() != 0, 1);
                    if (rq.size() != 0 && rq[0].lat >= 0) chk("latency", cyc - t0, rq[0].lat);
                end
                if (job_hs) begin
                    need = job_new_key || !loaded_m || job_key != key_m;
                    kfail = need && p_stuck;
                    err = kfail || p_rmode == 1 || p_rmode == 3;
                    if (need) cq.push_back('{op: OPC_KEY, d: job_key});
                    if (!kfail) cq.push_back('{op: OPC_ENC, d: {128'd0, job_block}});
                    kp = need ? 2 + p_kb : 0;
                    r.d = err ? '0 : job_block ^ job_key[127:0] ^ job_key[255:128] ^ MIX;
                    r.e = err;
                    r.kl = !err;
                    r.lat = !(ir_always && ir_hold == 0) ? -1 : kfail ? T + 3 : err ? 3 + kp + T : 3 + kp + (p_rmode == 2 ? T - 1 : p_rd);
                    rq.push_back(r);
                    if (err) loaded_m = 0;
                    else if (need) begin
                        loaded_m = 1;
                        key_m = job_key;
                    end
                    t0 = cyc;
                    c_kb = p_kb; c_stuck = p_stuck; c_rd = p_rd; c_rmode = p_rmode;
                end
                if (cmd_hs) begin
                    chk("cmd_expected", cq.size() != 0, 1);
                    if (cq.size() != 0) begin
                        c = cq.pop_front();
                        chk("cmd_opcode", aes_opcode, c.op);
                        chk("cmd_data", aes_data_in, c.d);
                    end
                    if (cmd_n == 0) begin
                        chk("first_cmd_opcode_key", aes_opcode, 5'd0);
                        chk("first_cmd_data_1", aes_data_in, 256'd1);
                    end
                    if (cmd_n == 1) begin
                        chk("second_cmd_opcode_enc", aes_opcode, 5'd1);
                        chk("second_cmd_data_45", aes_data_in, {128'd0, 128'h45});
                    end
                    cmd_n++;
                end
                if (out_hs) chk("late_result_not_acked", c_rmode == 3, 0);
                if (res_hs) begin
                    if (rq.size() != 0) begin
                        r = rq.pop_front();
                        chk("res_data", res_data, r.d);
                        chk("res_err", res_err, r.e);
                        chk("res_key_loaded", key_loaded, r.kl);
                        chk("cmds_consumed", cq.size(), 0);
                    end
                    if (res_n == 0) begin
                        chk("first_result_literal", res_data, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5E1);
                        chk("first_key_loaded", key_loaded, 1);
                    end
                    res_n++;
                end
            end
            pv_iv = !reset && aes_input_valid; pv_ir = aes_input_ready; pv_op = aes_opcode; pv_d = aes_data_in;
            pv_rv = !reset && res_valid; pv_rr = res_ready; pv_rd = res_data; pv_re = res_err;
            @(posedge clk);
            #1;
            if (rst_seen) begin
                busy_left = 0; busy_stuck = 0; armed = 0; late_hold = 0;
                aes_busy = 0; aes_output_valid = 0; aes_input_ready = 0; res_ready = 0;
            end else begin
                if (busy_left > 0 && !busy_stuck) busy_left--;
                if (cmd_hs && h_op == OPC_KEY) begin
                    core_key = h_d;
                    busy_left = c_kb;
                    busy_stuck = c_stuck;
                end
                aes_busy = busy_stuck || busy_left > 0;
                if (out_hs) begin
                    aes_output_valid = 0;
                    armed = 0;
                end
                if (cmd_hs && h_op == OPC_ENC && c_rmode != 1) begin
                    armed = 1;
                    res_cnt = c_rmode == 2 ? T - 1 : c_rmode == 3 ? T : c_rd;
                    res_val = h_d[127:0] ^ core_key[127:0] ^ core_key[255:128] ^ MIX;
                end
                if (armed && !aes_output_valid) begin
                    if (res_cnt == 0) begin
                        aes_output_valid = 1;
                        aes_data_out = res_val;
                        late_hold = 2;
                    end else res_cnt--;
                end else if (aes_output_valid && c_rmode == 3) begin
                    late_hold--;
                    if (late_hold == 0) begin
                        aes_output_valid = 0;
                        armed = 0;
                    end
                end
                if (ir_hold > 0 && aes_input_valid) begin
                    aes_input_ready = 0;
                    ir_hold--;
                end else aes_input_ready = ir_always ? 1'b1 : 1'($urandom_range(0, 2) != 0);
                if (rr_hold > 0 && res_valid) begin
                    res_ready = 0;
                    rr_hold--;
                end else res_ready = rr_always ? 1'b1 : 1'($urandom_range(0, 2) != 0);
            end
        end
    end

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1);
    end

    initial begin : main
        int n;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 8; j++) pool[i][j*32 +: 32] = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #2;
        reset = 0;
        offer(256'd1, 128'h45, 0, 2, 0, 0, 0);
        drain();
        offer(256'd1, 128'h77, 0, 0, 0, 0, 0);
        offer(256'd1, 128'h78, 0, 1, 0, 2, 0);
        offer(256'd1, 128'h88, 1, 0, 0, 1, 0);
        offer(pool[1], 128'h89, 0, 3, 0, 0, 0);
        drain();
        ir_hold = 5;
        offer(pool[1], 128'h99, 1, 0, 0, 0, 0);
        drain();
        rr_hold = 4;
        offer(pool[1], 128'h9A, 0, 0, 0, 0, 0);
        drain();
        offer(pool[0], 128'hAB, 0, 0, 0, 0, 1);
        drain();
        @(negedge clk);
        chk("key_loaded_cleared_after_timeout", key_loaded, 0);
        @(posedge clk);
        #2;
        offer(pool[0], 128'hAC, 0, 0, 0, 3, 0);
        offer(pool[0], 128'hAD, 0, 0, 0, 0, 2);
        offer(pool[0], 128'hAE, 0, 0, 0, 0, 3);
        offer(pool[0], 128'hAF, 0, 0, 0, 0, 0);
        offer(pool[2], 128'hB0, 0, 0, 1, 0, 0);
        offer(pool[2], 128'hB1, 0, 1, 0, 0, 0);
        drain();
        for (int i = 0; i < 150; i++) begin
            int sel, rm;
            sel = $urandom_range(0, 9);
            rm = sel < 7 ? 0 : sel == 7 ? 1 : sel == 8 ? 2 : 3;
            ir_always = 1'($urandom_range(0, 1));
            rr_always = 1'($urandom_range(0, 1));
            offer(pool[$urandom_range(0, 2)], {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 19) == 0, $urandom_range(0, T - 2), rm);
            drain();
        end
        ir_always = 1;
        rr_always = 1;
        offer(pool[0], 128'hC0, 1, 0, 0, 0, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!aes_output_ready && n < 50);
        chk("reached_wait_res", aes_output_ready, 1);
        repeat (2) @(posedge clk);
        #2;
        reset = 1;
        @(posedge clk);
        #2;
        reset = 0;
        cq.delete();
        rq.delete();
        loaded_m = 0;
        @(negedge clk);
        check_all_zero("abort");
        repeat (30) begin
            @(negedge clk);
            chk("no_result_after_abort", res_valid, 0);
        end
        @(posedge clk);
        #2;
        offer(pool[0], 128'hC1, 0, 0, 0, 1, 0);
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/aes_host_driver.md
Name: aes_host_driver

Overview:
- Command initiator that sits in front of the AES core and drives its valid/ready command port.
- Accepts one job per handshake from an upstream source. Each job is a 256-bit key, a 128-bit block and a new-key flag.
- Issues a load-key command (only when needed), then an encrypt command, and captures the core's 128-bit result.
- Returns the result (or a timeout error) to the upstream consumer over a valid/ready result port.

Parameters:
- OPC_KEY, 5'd0, opcode driven for the key-load command
- OPC_ENC, 5'd1, opcode driven for the encrypt command
- TIMEOUT, 1024, maximum wait cycles in WAIT_KEY or WAIT_RES before an error is declared (≥2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- job_valid  in  1  upstream job offered
- job_ready  out  1  driver can accept a job
- job_key  in  256  key
- job_block  in  128  plaintext block
- job_new_key  in  1  force key reload
- aes_input_valid  out  1  command valid to core
- aes_input_ready  in  1  core accepts command
- aes_opcode  out  5  command opcode
- aes_data_in  out  256  command payload
- aes_busy  in  1  core processing
- aes_output_valid  in  1  core result valid
- aes_output_ready  out  1  driver accepts result
- aes_data_out  in  128  core result
- res_valid  out  1  result offered upstream
- res_ready  in  1  consumer accepts result
- res_data  out  128  result block
- res_err  out  1  result is a timeout error
- key_loaded  out  1  core holds a valid key

Behaviour:
- Handshakes: a transfer occurs in a cycle where both valid and ready are high at the rising edge of clk. The driver holds valid and payload stable until that transfer occurs.
- Reset (synchronous, active-high): state=IDLE. All outputs are 0: job_ready, aes_input_valid, aes_opcode, aes_data_in, aes_output_ready, res_valid, res_data, res_err, key_loaded. The timeout counter is 0. Reset in any state aborts the job with no result delivered.
- The FSM is one-hot or binary, implementer's choice. States and transitions:
  - IDLE: job_ready=1. On job transfer, latch key, block and new_key.
    - If new_key=1, or key_loaded=0, or the latched key ≠ the stored key → SEND_KEY.
    - Otherwise → SEND_BLK.
  - SEND_KEY: aes_input_valid=1, aes_opcode=OPC_KEY, aes_data_in=key. On transfer → WAIT_KEY and clear the counter.
  - WAIT_KEY: wait for aes_busy=0, sampled no earlier than the cycle after acceptance. Then set key_loaded=1, store the key, → SEND_BLK. If the counter reaches TIMEOUT → ERR.
  - SEND_BLK: aes_input_valid=1, aes_opcode=OPC_ENC, aes_data_in={128'd0, block}. On transfer → WAIT_RES and clear the counter.
  - WAIT_RES: aes_output_ready=1. On an aes_output_valid transfer, capture aes_data_out into res_data, set res_err=0, → DELIVER. If the counter reaches TIMEOUT → ERR.
  - ERR: single cycle. Set res_data=0, res_err=1, key_loaded=0, → DELIVER.
  - DELIVER: res_valid=1. On res_ready → IDLE; res_valid falls next cycle.
- Latency: one job flows from job transfer through SEND_*/WAIT_*/DELIVER.
  - Minimum, key skipped, core responds in 1 cycle: job accept → res_valid = 3 cycles.
- Output rules:
  - aes_input_valid is high only in SEND_* states.
  - aes_output_ready is high only in WAIT_RES.
  - An aes_output_valid arriving in any other state is ignored (not acknowledged).
- Timeout counter: increments each cycle in WAIT_*, saturating. Timeout fires on the cycle the count equals TIMEOUT-1 with no completion. If completion and timeout occur in the same cycle, completion wins.
- Stored-key compare is 256-bit equality.
- Only one job is in flight; no buffering beyond one result register.

Test Plan:
- First job: key=256'd1, block=128'h45, new_key=0 → OPC_KEY with data 1 is issued, then OPC_ENC with data {128'd0, 128'h45}. The core's returned 128'hA5A5… appears on res_data with res_err=0, and key_loaded=1.
- Second job with the same key, new_key=0 → no OPC_KEY issued; exactly one OPC_ENC command. Then repeat with new_key=1 → OPC_KEY is reissued.
- Backpressure: aes_input_ready held low for 5 cycles → aes_input_valid, opcode and data remain stable for all 5 cycles. res_ready held low for 4 cycles → res_valid and res_data held, job_ready=0 throughout.
- Timeout: core never asserts aes_output_valid, TIMEOUT=8 → res_valid with res_err=1 and res_data=0 after 8 WAIT_RES cycles; key_loaded=0. The next job reloads the key.
- Completion coincident with the timeout cycle → res_err=0 and the captured data is delivered.
- Reset asserted in WAIT_RES → next cycle all outputs are 0, state is IDLE, and no res_valid is ever produced for the aborted job.
